zx_cpu_ce_gen: RTL and testbench

//  Parametrised clock-enable generator for the Spectrum core: one master counter on clk_sys

---
 rtl/zx_cpu_ce_gen.sv | 115 +++++++++++
 tb/tb_zx_cpu_ce_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/zx_cpu_ce_gen.sv
// zx_cpu_ce_gen: CPU/PSG/pixel clock-enable generator with safe speed-switch handshake
// Ports:
//   i_clk_sys, i_reset_n          system clock, async active-low reset
//   i_speed_req                   requested speed level (clamped to NUM_LVL-1)
//   i_sync_p, i_sync_n            ULA-derived CPU enables used at level 0
//   i_ram_ready                   SDRAM ready, stalls fast levels when low
//   o_ce_cpu_p, o_ce_cpu_n        gated CPU enables
//   o_ce_cpu                      gated turbo p tick for FDC/tape timing
//   o_ce_psg, o_ce_7mp, o_ce_7mn  fixed PSG and pixel enables
//   o_cpu_en, o_speed_cur         CPU running flag, level in force
//   o_switching                   high from speed change until CPU resumes
module zx_cpu_ce_gen #(
  parameter int LVL_W     = 3,
  parameter int NUM_LVL   = 5,
  parameter int PSG_LOG2  = 6,
  parameter int PIX_LOG2  = 4,
  parameter int SETTLE_W  = 2,
  parameter int STALL_LVL = 3
) (
  input  logic             i_clk_sys,
  input  logic             i_reset_n,
  input  logic [LVL_W-1:0] i_speed_req,
  input  logic             i_sync_p,
  input  logic             i_sync_n,
  input  logic             i_ram_ready,
  output logic             o_ce_cpu_p,
  output logic             o_ce_cpu_n,
  output logic             o_ce_cpu,
  output logic             o_ce_psg,
  output logic             o_ce_7mp,
  output logic             o_ce_7mn,
  output logic             o_cpu_en,
  output logic [LVL_W-1:0] o_speed_cur,
  output logic             o_switching
);
  localparam int CW0 = NUM_LVL > PSG_LOG2 ? NUM_LVL : PSG_LOG2;
  localparam int CW  = CW0 > PIX_LOG2 ? CW0 : PIX_LOG2;
  logic [CW-1:0]       r_cnt;
  logic                r_tp, r_tn, r_psg, r_7mp, r_7mn, r_cpu_en, r_switching;
  logic [LVL_W-1:0]    r_speed_cur;
  logic [SETTLE_W-1:0] r_settle;
  logic [LVL_W-1:0]    w_shamt, w_req;
  logic [CW:0]         w_sh;
  logic [CW-1:0]       w_mask, w_half;
  logic                w_sp, w_sn, w_lvl0;
  logic                w_cpu_en_nx, w_switching_nx;
  logic [LVL_W-1:0]    w_speed_nx;
  logic [SETTLE_W-1:0] w_settle_nx;
  assign w_shamt = LVL_W'(NUM_LVL) - r_speed_cur;
  assign w_sh    = ((CW+1)'(1) << w_shamt) - (CW+1)'(1);
  assign w_mask  = w_sh[CW-1:0];
  // half-period point is the top set bit of the mask
  assign w_half  = w_mask ^ (w_mask >> 1);
  assign w_req   = (i_speed_req >= LVL_W'(NUM_LVL)) ? LVL_W'(NUM_LVL - 1) : i_speed_req;
  assign w_lvl0  = r_speed_cur == '0;
  assign w_sp    = w_lvl0 ? i_sync_p : r_tp;
  assign w_sn    = w_lvl0 ? i_sync_n : r_tn;
  assign o_ce_cpu_p  = r_cpu_en & w_sp;
  assign o_ce_cpu_n  = r_cpu_en & w_sn;
  assign o_ce_cpu    = r_cpu_en & r_tp;
  assign o_ce_psg    = r_psg;
  assign o_ce_7mp    = r_7mp;
  assign o_ce_7mn    = r_7mn;
  assign o_cpu_en    = r_cpu_en;
  assign o_speed_cur = r_speed_cur;
  assign o_switching = r_switching;
  // handshake only advances on the selected n tick so level changes land between CPU half-cycles
  always_comb begin
    w_cpu_en_nx    = r_cpu_en;
    w_switching_nx = r_switching;
    w_speed_nx     = r_speed_cur;
    w_settle_nx    = r_settle;
    if (w_sn) begin
      if (w_req != r_speed_cur) begin
        w_cpu_en_nx    = 1'b0;
        w_settle_nx    = SETTLE_W'(1);
        w_speed_nx     = w_req;
        w_switching_nx = 1'b1;
      end else begin
        w_settle_nx = (r_settle != '0) ? r_settle + SETTLE_W'(1) : r_settle;
        if (!r_cpu_en && r_settle == '0 && i_ram_ready) begin
          w_cpu_en_nx    = 1'b1;
          w_switching_nx = 1'b0;
        end else if (r_speed_cur >= LVL_W'(STALL_LVL) && !i_ram_ready) begin
          w_cpu_en_nx = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      r_tp        <= 1'b0;
      r_tn        <= 1'b0;
      r_psg       <= 1'b0;
      r_7mp       <= 1'b0;
      r_7mn       <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_switching <= 1'b0;
      r_speed_cur <= '0;
      r_settle    <= '0;
    end else begin
      r_cnt       <= r_cnt + CW'(1);
      r_tp        <= (r_cnt & w_mask) == '0;
      r_tn        <= (r_cnt & w_mask) == w_half;
      r_psg       <= r_cnt[PSG_LOG2-1:0] == '0;
      r_7mp       <= r_cnt[PIX_LOG2-1:0] == '0;
      r_7mn       <= r_cnt[PIX_LOG2-1:0] == PIX_LOG2'(1 << (PIX_LOG2 - 1));
      r_cpu_en    <= w_cpu_en_nx;
      r_switching <= w_switching_nx;
      r_speed_cur <= w_speed_nx;
      r_settle    <= w_settle_nx;
    end
  end
endmodule

// File: tb/tb_zx_cpu_ce_gen.sv
// tb_zx_cpu_ce_gen: table, hand-sequence and random checks of zx_cpu_ce_gen against a cycle model
module tb_zx_cpu_ce_gen;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] speed_req = '0;
  logic       sync_p = 1'b0, sync_n = 1'b0, ram_ready = 1'b1;
  logic       ce_cpu_p, ce_cpu_n, ce_cpu, ce_psg, ce_7mp, ce_7mn, cpu_en, switching;
  logic [2:0] speed_cur;
  int tests = 0, fails = 0, tcyc = 0;
  bit rnd_sync = 0;
  int m_cnt, m_lvl, m_pend;
  bit m_en, m_sw, m_tp, m_tn, m_psg, m_7p, m_7n;
  typedef struct {
    logic [2:0] req;
    logic       rdy;
    int         n;
    logic       en;
    logic [2:0] spd;
    logic       sw;
  } vec_t;
  vec_t tbl[13];

  zx_cpu_ce_gen dut (
    .i_clk_sys(clk), .i_reset_n(reset_n), .i_speed_req(speed_req),
    .i_sync_p(sync_p), .i_sync_n(sync_n), .i_ram_ready(ram_ready),
    .o_ce_cpu_p(ce_cpu_p), .o_ce_cpu_n(ce_cpu_n), .o_ce_cpu(ce_cpu),
    .o_ce_psg(ce_psg), .o_ce_7mp(ce_7mp), .o_ce_7mn(ce_7mn),
    .o_cpu_en(cpu_en), .o_speed_cur(speed_cur), .o_switching(switching)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] outs();
    return {ce_cpu_p, ce_cpu_n, ce_cpu, ce_psg, ce_7mp, ce_7mn, cpu_en, speed_cur, switching};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, tcyc, got, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_lvl = 0; m_pend = 0;
    m_en = 0; m_sw = 0; m_tp = 0; m_tn = 0; m_psg = 0; m_7p = 0; m_7n = 0;
  endtask

  // one clock: drive sync, compare against the model, advance the model, wait for next negedge
  task automatic cyc();
    bit sp, sn;
    int per, tgt;
    logic [11:0] exp;
    if (rnd_sync) begin
      sync_p = $urandom_range(0, 5) == 0;
      sync_n = $urandom_range(0, 5) == 0;
    end else begin
      sync_p = (tcyc % 16) == 0;
      sync_n = (tcyc % 16) == 8;
    end
    #1;
    sp = (m_lvl == 0) ? sync_p : m_tp;
    sn = (m_lvl == 0) ? sync_n : m_tn;
    exp = {m_en & sp, m_en & sn, m_en & m_tp, m_psg, m_7p, m_7n, m_en, 3'(m_lvl), m_sw};
    check("cycle_outputs", outs(), exp);
    per = 1 << (5 - m_lvl);
    tgt = (speed_req > 3'd4) ? 4 : int'(speed_req);
    m_tp = (m_cnt % per) == 0;
    m_tn = (m_cnt % per) == per / 2;
    m_psg = (m_cnt % 64) == 0;
    m_7p = (m_cnt % 16) == 0;
    m_7n = (m_cnt % 16) == 8;
    if (sn) begin
      if (tgt != m_lvl) begin
        m_en = 0; m_sw = 1; m_lvl = tgt; m_pend = 3;
      end else begin
        if (!m_en && m_pend == 0 && ram_ready) begin
          m_en = 1; m_sw = 0;
        end else if (m_lvl >= 3 && !ram_ready) m_en = 0;
        if (m_pend > 0) m_pend--;
      end
    end
    m_cnt = (m_cnt + 1) % 64;
    tcyc++;
    @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic en, input logic [2:0] spd, input logic sw);
    #1;
    check(name, {7'b0, cpu_en, speed_cur, switching}, {7'b0, en, spd, sw});
  endtask

  initial begin
    tbl[0]  = '{3'd0, 1'b1, 32, 1'b1, 3'd0, 1'b0};
    tbl[1]  = '{3'd4, 1'b1, 4,  1'b1, 3'd0, 1'b0};
    tbl[2]  = '{3'd4, 1'b1, 8,  1'b0, 3'd4, 1'b1};
    tbl[3]  = '{3'd4, 1'b1, 6,  1'b1, 3'd4, 1'b0};
    tbl[4]  = '{3'd4, 1'b0, 5,  1'b0, 3'd4, 1'b0};
    tbl[5]  = '{3'd4, 1'b1, 2,  1'b1, 3'd4, 1'b0};
    tbl[6]  = '{3'd2, 1'b1, 4,  1'b0, 3'd2, 1'b1};
    tbl[7]  = '{3'd2, 1'b1, 25, 1'b1, 3'd2, 1'b0};
    tbl[8]  = '{3'd2, 1'b0, 16, 1'b1, 3'd2, 1'b0};
    tbl[9]  = '{3'd7, 1'b1, 8,  1'b0, 3'd4, 1'b1};
    tbl[10] = '{3'd1, 1'b1, 4,  1'b0, 3'd1, 1'b1};
    tbl[11] = '{3'd1, 1'b1, 50, 1'b0, 3'd1, 1'b1};
    tbl[12] = '{3'd1, 1'b1, 6,  1'b1, 3'd1, 1'b0};
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", outs(), 12'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      speed_req = tbl[i].req;
      ram_ready = tbl[i].rdy;
      for (int k = 0; k < tbl[i].n; k++) cyc();
      check_state($sformatf("table_%0d", i), tbl[i].en, tbl[i].spd, tbl[i].sw);
    end
    speed_req = 3'd3;
    ram_ready = 1'b1;
    repeat (16) cyc();
    check_state("mid_switch", 1'b0, 3'd3, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), 12'b0);
    @(negedge clk);
    #1;
    check("reset_held", outs(), 12'b0);
    @(negedge clk);
    m_reset();
    tcyc = 0;
    speed_req = 3'd0;
    reset_n = 1'b1;
    repeat (32) cyc();
    check_state("recovery", 1'b1, 3'd0, 1'b0);
    rnd_sync = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) speed_req = 3'($urandom_range(0, 7));
      ram_ready = $urandom_range(0, 5) != 0;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
